tlc_ctrl_param: RTL and testbench

TLC_CTRL_PARAM -- requirements
Module: tlc_ctrl_param

---
 rtl/tlc_pkg.sv | 57 +++++
 rtl/tlc_ctrl_param_chk.sv | 27 ++
 rtl/tlc_sync.sv | 32 +++
 rtl/tlc_ctrl_param.sv | 182 ++++++++++++++++++
 tb/tb_tlc_ctrl_param.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the highway/farm-road traffic-light controller:
//   - tlc_state_e  : controller state codes (also driven out on the debug port)
//   - LIGHT_*      : 2-bit lamp encodings (00 off, 01 red, 10 yellow, 11 green)
//   - tlc_lights_t : highway/farm lamp pair
//   - tlc_decode() : state + flash phase -> lamp pair
// ---------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED1  = 3'd0,
        ST_HWY_GRN  = 3'd1,
        ST_HWY_YEL  = 3'd2,
        ST_ALLRED2  = 3'd3,
        ST_FARM_GRN = 3'd4,
        ST_FARM_YEL = 3'd5,
        ST_FLASH    = 3'd6
    } tlc_state_e;

    localparam logic [1:0] LIGHT_OFF = 2'b00;
    localparam logic [1:0] LIGHT_RED = 2'b01;
    localparam logic [1:0] LIGHT_YEL = 2'b10;
    localparam logic [1:0] LIGHT_GRN = 2'b11;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] farm;
    } tlc_lights_t;

    // Lamp decode. Any code outside the enumerated set shows red/red, which
    // is the safe aspect while the FSM recovers to ALLRED1.
    function automatic tlc_lights_t tlc_decode(input tlc_state_e st, input logic phase);
        tlc_lights_t l;
        l.hwy  = LIGHT_RED;
        l.farm = LIGHT_RED;
        case (st)
            ST_ALLRED1, ST_ALLRED2: begin l.hwy = LIGHT_RED; l.farm = LIGHT_RED; end
            ST_HWY_GRN:             begin l.hwy = LIGHT_GRN; l.farm = LIGHT_RED; end
            ST_HWY_YEL:             begin l.hwy = LIGHT_YEL; l.farm = LIGHT_RED; end
            ST_FARM_GRN:            begin l.hwy = LIGHT_RED; l.farm = LIGHT_GRN; end
            ST_FARM_YEL:            begin l.hwy = LIGHT_RED; l.farm = LIGHT_YEL; end
            ST_FLASH: begin
                if (phase) begin
                    l.hwy  = LIGHT_YEL;
                    l.farm = LIGHT_RED;
                end else begin
                    l.hwy  = LIGHT_OFF;
                    l.farm = LIGHT_OFF;
                end
            end
            default:                begin l.hwy = LIGHT_RED; l.farm = LIGHT_RED; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_ctrl_param_chk.sv
// ---------------------------------------------------------------------------
// tlc_ctrl_param_chk
// Safety checker for tlc_ctrl_param, sampled on the falling clock edge:
//   - never green on both roads, never green on one road with yellow on the
//     other;
//   - the unused state code 7 never appears.
//   clk_i   : controller clock
//   hwy_i   : highway lamp code
//   farm_i  : farm lamp code
//   state_i : debug state code
// ---------------------------------------------------------------------------
module tlc_ctrl_param_chk
    import tlc_pkg::*;
(
    input logic       clk_i,
    input logic [1:0] hwy_i,
    input logic [1:0] farm_i,
    input logic [2:0] state_i
);

    a_no_conflict: assert property (@(negedge clk_i)
        !((hwy_i == LIGHT_GRN && (farm_i == LIGHT_GRN || farm_i == LIGHT_YEL)) ||
          (farm_i == LIGHT_GRN && hwy_i == LIGHT_YEL)));

    a_state_legal: assert property (@(negedge clk_i) state_i != 3'd7);

endmodule

// File: rtl/tlc_sync.sv
// ---------------------------------------------------------------------------
// tlc_sync
// Two-flop synchroniser for one asynchronous level input.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset (both flops cleared)
//   d_i   : asynchronous input
//   q_o   : synchronised output, two clk_i edges of latency
// ---------------------------------------------------------------------------
module tlc_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability-settling flop followed by the output flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tlc_ctrl_param.sv
// ---------------------------------------------------------------------------
// tlc_ctrl_param
// Highway / farm-road traffic-light controller with a night-flash mode.
//   Clk           : single clock
//   Rst           : asynchronous active-high reset
//   farmSensor    : asynchronous farm-road vehicle detector
//   flashMode     : asynchronous night-flash request
//   highwaySignal : highway lamp (00 off, 01 red, 10 yellow, 11 green)
//   farmSignal    : farm lamp, same encoding
//   state         : current state code (debug)
//   farmReq       : latched pending farm request
// All dwell times are in clock cycles. Lamps are decoded combinationally
// from the state register and flash phase, so reset shows red/red at once.
// ---------------------------------------------------------------------------
module tlc_ctrl_param
    import tlc_pkg::*;
#(
    parameter int CNT_W      = 31,
    parameter int T_ALLRED   = 50000000,
    parameter int T_HWY_MIN  = 1500000000,
    parameter int T_YEL      = 150000000,
    parameter int T_FARM_MIN = 100000000,
    parameter int T_FARM_MAX = 750000000,
    parameter int T_FLASH    = 25000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       farmSensor,
    input  logic       flashMode,
    output logic [1:0] highwaySignal,
    output logic [1:0] farmSignal,
    output logic [2:0] state,
    output logic       farmReq
);

    // Parameter sanity: every dwell non-zero, representable in the counter,
    // and the farm minimum no larger than the farm maximum.
    localparam logic [63:0] CNT_LIMIT = 64'd1 << CNT_W;

    if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
        $error("tlc_ctrl_param: CNT_W out of range");
    end
    if (T_ALLRED < 1 || T_HWY_MIN < 1 || T_YEL < 1 ||
        T_FARM_MIN < 1 || T_FARM_MAX < 1 || T_FLASH < 1) begin : g_bad_zero
        $error("tlc_ctrl_param: every T_* must be at least 1");
    end
    if (T_FARM_MIN > T_FARM_MAX) begin : g_bad_farm
        $error("tlc_ctrl_param: T_FARM_MIN exceeds T_FARM_MAX");
    end
    if (64'(T_ALLRED) >= CNT_LIMIT || 64'(T_HWY_MIN) >= CNT_LIMIT ||
        64'(T_YEL) >= CNT_LIMIT || 64'(T_FARM_MIN) >= CNT_LIMIT ||
        64'(T_FARM_MAX) >= CNT_LIMIT || 64'(T_FLASH) >= CNT_LIMIT) begin : g_bad_width
        $error("tlc_ctrl_param: a T_* does not fit in CNT_W bits");
    end

    // Counter values on the last cycle of each dwell.
    localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] HWY_MIN_LAST  = CNT_W'(T_HWY_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST      = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] FARM_MIN_LAST = CNT_W'(T_FARM_MIN - 1);
    localparam logic [CNT_W-1:0] FARM_MAX_LAST = CNT_W'(T_FARM_MAX - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST    = CNT_W'(T_FLASH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    logic             sensor_s;
    logic             flash_s;
    tlc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             phase_q, phase_d;
    logic             req_q, req_d;
    tlc_lights_t      lights_s;

    tlc_sync u_sync_sensor (.clk_i(Clk), .rst_i(Rst), .d_i(farmSensor), .q_o(sensor_s));
    tlc_sync u_sync_flash  (.clk_i(Clk), .rst_i(Rst), .d_i(flashMode),  .q_o(flash_s));

    // Next-state decode. Flash overrides both green dwells; a coincident
    // timeout selects the same yellow state, so the yellow is entered once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ALLRED1: begin
                if (cnt_q == ALLRED_LAST) state_d = ST_HWY_GRN;
                else                      state_d = state_q;
            end
            ST_HWY_GRN: begin
                if (flash_s || (req_q && cnt_q >= HWY_MIN_LAST)) state_d = ST_HWY_YEL;
                else                                             state_d = state_q;
            end
            ST_HWY_YEL: begin
                if (cnt_q == YEL_LAST) state_d = flash_s ? ST_FLASH : ST_ALLRED2;
                else                   state_d = state_q;
            end
            ST_ALLRED2: begin
                if (cnt_q == ALLRED_LAST) state_d = ST_FARM_GRN;
                else                      state_d = state_q;
            end
            ST_FARM_GRN: begin
                if (flash_s || cnt_q == FARM_MAX_LAST ||
                    (!sensor_s && cnt_q >= FARM_MIN_LAST)) state_d = ST_FARM_YEL;
                else                                       state_d = state_q;
            end
            ST_FARM_YEL: begin
                if (cnt_q == YEL_LAST) state_d = flash_s ? ST_FLASH : ST_ALLRED1;
                else                   state_d = state_q;
            end
            ST_FLASH: begin
                if (!flash_s) state_d = ST_ALLRED1;
                else          state_d = state_q;
            end
            default: state_d = ST_ALLRED1;
        endcase
    end

    // Dwell counter restarts with every state change and saturates;
    // flash phase timer only runs while remaining in FLASH.
    always_comb begin
        cnt_d       = cnt_q;
        flash_cnt_d = '0;
        phase_d     = 1'b0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (state_q == ST_FLASH && state_d == ST_FLASH) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + CNT_ONE;
                phase_d     = phase_q;
            end
        end else begin
            flash_cnt_d = '0;
            phase_d     = 1'b0;
        end
    end

    // Farm request: entry to FARM_GRN clears it even if the sensor is high
    // in the same cycle; the sensor is ignored while farm has right of way.
    always_comb begin
        req_d = req_q;
        if (state_d == ST_FARM_GRN && state_q != ST_FARM_GRN) begin
            req_d = 1'b0;
        end else if (sensor_s && state_q != ST_FARM_GRN && state_q != ST_FARM_YEL) begin
            req_d = 1'b1;
        end else begin
            req_d = req_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_ALLRED1;
            cnt_q       <= '0;
            flash_cnt_q <= '0;
            phase_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
            req_q       <= req_d;
        end
    end

    // Lamp decode from registered state and phase only.
    always_comb begin
        lights_s = tlc_decode(state_q, phase_q);
    end

    assign highwaySignal = lights_s.hwy;
    assign farmSignal    = lights_s.farm;
    assign state         = state_q;
    assign farmReq       = req_q;

endmodule

// File: tb/tb_tlc_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_tlc_ctrl_param
// Directed, table-driven bench for tlc_ctrl_param with short dwell times.
// Each table row gives the inputs applied for one clock and the expected
// {state, highwaySignal, farmSignal, farmReq} after that clock edge.
// ---------------------------------------------------------------------------
module tb_tlc_ctrl_param;

    localparam int CNT_W      = 8;
    localparam int T_ALLRED   = 2;
    localparam int T_HWY_MIN  = 8;
    localparam int T_YEL      = 3;
    localparam int T_FARM_MIN = 2;
    localparam int T_FARM_MAX = 6;
    localparam int T_FLASH    = 2;

    localparam logic [1:0] O = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] G = 2'b11;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       farmSensor;
    logic       flashMode;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic [2:0] state;
    logic       farmReq;

    typedef struct {
        logic       rst;
        logic       sensor;
        logic       flash;
        logic [2:0] st;
        logic [1:0] hwy;
        logic [1:0] farm;
        logic       req;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    tlc_ctrl_param #(
        .CNT_W(CNT_W), .T_ALLRED(T_ALLRED), .T_HWY_MIN(T_HWY_MIN), .T_YEL(T_YEL),
        .T_FARM_MIN(T_FARM_MIN), .T_FARM_MAX(T_FARM_MAX), .T_FLASH(T_FLASH)
    ) dut (
        .Clk(Clk), .Rst(Rst), .farmSensor(farmSensor), .flashMode(flashMode),
        .highwaySignal(highwaySignal), .farmSignal(farmSignal),
        .state(state), .farmReq(farmReq)
    );

    tlc_ctrl_param_chk u_chk (
        .clk_i(Clk), .hwy_i(highwaySignal), .farm_i(farmSignal), .state_i(state)
    );

    task automatic add(input int n, input logic r, input logic s, input logic f,
                       input logic [2:0] st, input logic [1:0] h, input logic [1:0] fm,
                       input logic q);
        vec_t v;
        v.rst = r; v.sensor = s; v.flash = f; v.st = st; v.hwy = h; v.farm = fm; v.req = q;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst sensor flash | state hwy farm req   (count = rows)
        // Idle highway: full ALLRED1 dwell then highway green held.
        add(1,  1'b1, 1'b0, 1'b0, 3'd0, R, R, 1'b0);
        add(1,  1'b0, 1'b0, 1'b0, 3'd0, R, R, 1'b0);
        add(11, 1'b0, 1'b0, 1'b0, 3'd1, G, R, 1'b0);
        // Fresh start, 1-cycle sensor pulse in highway-green cycle 3.
        add(1,  1'b1, 1'b0, 1'b0, 3'd0, R, R, 1'b0);
        add(1,  1'b0, 1'b0, 1'b0, 3'd0, R, R, 1'b0);
        add(3,  1'b0, 1'b0, 1'b0, 3'd1, G, R, 1'b0);
        add(1,  1'b0, 1'b1, 1'b0, 3'd1, G, R, 1'b0);
        add(1,  1'b0, 1'b0, 1'b0, 3'd1, G, R, 1'b0);
        add(3,  1'b0, 1'b0, 1'b0, 3'd1, G, R, 1'b1);
        add(3,  1'b0, 1'b0, 1'b0, 3'd2, Y, R, 1'b1);
        add(2,  1'b0, 1'b0, 1'b0, 3'd3, R, R, 1'b1);
        add(2,  1'b0, 1'b0, 1'b0, 3'd4, R, G, 1'b0);
        add(3,  1'b0, 1'b0, 1'b0, 3'd5, R, Y, 1'b0);
        add(2,  1'b0, 1'b0, 1'b0, 3'd0, R, R, 1'b0);
        add(1,  1'b0, 1'b0, 1'b0, 3'd1, G, R, 1'b0);
        // Sensor held high: farm green runs to its maximum, request re-arms.
        add(2,  1'b0, 1'b1, 1'b0, 3'd1, G, R, 1'b0);
        add(5,  1'b0, 1'b1, 1'b0, 3'd1, G, R, 1'b1);
        add(3,  1'b0, 1'b1, 1'b0, 3'd2, Y, R, 1'b1);
        add(2,  1'b0, 1'b1, 1'b0, 3'd3, R, R, 1'b1);
        add(6,  1'b0, 1'b1, 1'b0, 3'd4, R, G, 1'b0);
        add(3,  1'b0, 1'b1, 1'b0, 3'd5, R, Y, 1'b0);
        add(1,  1'b0, 1'b1, 1'b0, 3'd0, R, R, 1'b0);
        add(1,  1'b0, 1'b1, 1'b0, 3'd0, R, R, 1'b1);
        add(8,  1'b0, 1'b1, 1'b0, 3'd1, G, R, 1'b1);
        add(3,  1'b0, 1'b1, 1'b0, 3'd2, Y, R, 1'b1);
        add(2,  1'b0, 1'b1, 1'b0, 3'd3, R, R, 1'b1);
        add(1,  1'b0, 1'b1, 1'b0, 3'd4, R, G, 1'b0);
        // Flash request during farm green, then released.
        add(2,  1'b0, 1'b1, 1'b1, 3'd4, R, G, 1'b0);
        add(3,  1'b0, 1'b1, 1'b1, 3'd5, R, Y, 1'b0);
        add(1,  1'b0, 1'b1, 1'b1, 3'd6, O, O, 1'b0);
        add(1,  1'b0, 1'b1, 1'b1, 3'd6, O, O, 1'b1);
        add(2,  1'b0, 1'b1, 1'b1, 3'd6, Y, R, 1'b1);
        add(2,  1'b0, 1'b1, 1'b1, 3'd6, O, O, 1'b1);
        add(1,  1'b0, 1'b1, 1'b1, 3'd6, Y, R, 1'b1);
        add(1,  1'b0, 1'b1, 1'b0, 3'd6, Y, R, 1'b1);
        add(1,  1'b0, 1'b1, 1'b0, 3'd6, O, O, 1'b1);
        add(2,  1'b0, 1'b1, 1'b0, 3'd0, R, R, 1'b1);
        add(1,  1'b0, 1'b1, 1'b0, 3'd1, G, R, 1'b1);

        Rst = 1'b1;
        farmSensor = 1'b0;
        flashMode = 1'b0;
        #2;
        check("reset_state", {state, highwaySignal, farmSignal, farmReq},
              {3'd0, 2'b01, 2'b01, 1'b0});
        @(negedge Clk);

        for (int i = 0; i < vecs.size(); i++) begin
            Rst        = vecs[i].rst;
            farmSensor = vecs[i].sensor;
            flashMode  = vecs[i].flash;
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("vec%0d", i), {state, highwaySignal, farmSignal, farmReq},
                  {vecs[i].st, vecs[i].hwy, vecs[i].farm, vecs[i].req});
        end

        // Asynchronous reset in the middle of highway yellow.
        farmSensor = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        check("mid_hwy_yel", {state, highwaySignal, farmSignal, 1'b0},
              {3'd2, 2'b10, 2'b01, 1'b0});
        @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        check("async_rst_out", {state, highwaySignal, farmSignal, farmReq},
              {3'd0, 2'b01, 2'b01, 1'b0});
        check("async_rst_cnt", dut.cnt_q, 8'd0);
        #1 Rst = 1'b0;
        #1;
        check("release_state", {5'd0, state}, 8'd0);
        check("release_cnt", dut.cnt_q, 8'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("release_dwell1", {5'd0, state}, 8'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("release_dwell2", {state, highwaySignal, farmSignal, 1'b0},
              {3'd1, 2'b11, 2'b01, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
